// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states and round-robin source IDs.
// Source ID bit 0 selects read/write, bit 1 selects the video channel.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WREQ  = 3'd2,
        ST_WBUSY = 3'd3,
        ST_RREQ  = 3'd4,
        ST_RBUSY = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SRC_W0 = 2'd0,
        SRC_R0 = 2'd1,
        SRC_W1 = 2'd2,
        SRC_R1 = 2'd3
    } src_t;

    localparam int NUM_SRC = 4;

    function automatic logic src_is_read(input src_t s);
        return s[0];
    endfunction

    function automatic logic src_chan(input src_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/sdram_stream_ptr.sv
// Frame offset pointer for one stream: advances by one burst per completed burst,
// wraps at the frame end, and defers a frame restart that arrives mid-burst.
module sdram_stream_ptr #(
    parameter int          BURST       = 256,
    parameter logic [23:0] FRAME_WORDS = 24'd384000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        busy,
    input  logic        burst_end,
    output logic [23:0] offset
);

    logic        pending;
    logic [23:0] step;

    assign step = offset + 24'(BURST);

    // A restart seen while this stream's address is latched must not disturb it,
    // so it is remembered and applied when the burst completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset  <= '0;
            pending <= 1'b0;
        end else if (burst_end) begin
            offset  <= (pending || frame_start || step == FRAME_WORDS) ? 24'd0 : step;
            pending <= 1'b0;
        end else if (frame_start) begin
            if (busy)
                pending <= 1'b1;
            else
                offset  <= '0;
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter sharing the SDRAM controller write/read ports between two
// video channels (W0,R0,W1,R1); holds the request FSM and the address/select registers.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int          BURST       = 256,
    parameter logic [23:0] FRAME_WORDS = 24'd384000,
    parameter logic [23:0] BASE_CH0    = 24'h000000,
    parameter logic [23:0] BASE_CH1    = 24'h400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic [19:0] wr_level,
    input  logic [19:0] rd_space,
    input  logic [1:0]  rd_en,
    input  logic [1:0]  wr_frame_start,
    input  logic [1:0]  rd_frame_start,
    output logic        sdram_wr_req,
    input  logic        sdram_wr_ack,
    output logic [23:0] sdram_wr_addr,
    output logic [9:0]  sdram_wr_burst,
    output logic        sdram_rd_req,
    input  logic        sdram_rd_ack,
    output logic [23:0] sdram_rd_addr,
    output logic [9:0]  sdram_rd_burst,
    output logic        wr_sel,
    output logic        rd_sel
);

    localparam logic [9:0] BURST_W = 10'(BURST);

    state_t      state, state_nxt;
    src_t        last_src, cur_src, grant_src;
    logic        grant, any_elig, in_flight, burst_done;
    logic [3:0]  elig, busy, burst_end, frame_start;
    logic [23:0] offset [NUM_SRC];
    logic [23:0] grant_addr;

    assign sdram_wr_burst = BURST_W;
    assign sdram_rd_burst = BURST_W;

    assign elig[0] = wr_level[9:0]   >= BURST_W;
    assign elig[1] = rd_en[0] && rd_space[9:0]   >= BURST_W;
    assign elig[2] = wr_level[19:10] >= BURST_W;
    assign elig[3] = rd_en[1] && rd_space[19:10] >= BURST_W;

    assign frame_start = {rd_frame_start[1], wr_frame_start[1], rd_frame_start[0], wr_frame_start[0]};

    // Search starts just after the last grant; i=4 revisits the last source itself.
    always_comb begin
        grant_src = last_src;
        any_elig  = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (!any_elig && elig[2'(last_src + 2'(i))]) begin
                any_elig  = 1'b1;
                grant_src = src_t'(2'(last_src + 2'(i)));
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            ST_INIT:  if (sdram_init_done) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (!sdram_init_done) begin
                    state_nxt = ST_INIT;
                end else if (any_elig) begin
                    grant     = 1'b1;
                    state_nxt = src_is_read(grant_src) ? ST_RREQ : ST_WREQ;
                end
            end
            ST_WREQ:  if (sdram_wr_ack)  state_nxt = ST_WBUSY;
            ST_WBUSY: if (!sdram_wr_ack) state_nxt = ST_IDLE;
            ST_RREQ:  if (sdram_rd_ack)  state_nxt = ST_RBUSY;
            ST_RBUSY: if (!sdram_rd_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    assign in_flight  = state inside {ST_WREQ, ST_WBUSY, ST_RREQ, ST_RBUSY};
    assign burst_done = (state == ST_WBUSY && !sdram_wr_ack) || (state == ST_RBUSY && !sdram_rd_ack);
    assign grant_addr = (src_chan(grant_src) ? BASE_CH1 : BASE_CH0) + offset[grant_src];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_ptr
        assign busy[g]      = (in_flight && cur_src == 2'(g)) || (grant && grant_src == 2'(g));
        assign burst_end[g] = burst_done && cur_src == 2'(g);

        sdram_stream_ptr #(
            .BURST       (BURST),
            .FRAME_WORDS (FRAME_WORDS)
        ) u_ptr (
            .clk         (clk),
            .rst_n       (rst_n),
            .frame_start (frame_start[g]),
            .busy        (busy[g]),
            .burst_end   (burst_end[g]),
            .offset      (offset[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_src      <= SRC_R1;
            cur_src       <= SRC_W0;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            sdram_wr_addr <= '0;
            sdram_rd_addr <= '0;
            wr_sel        <= 1'b0;
            rd_sel        <= 1'b0;
        end else begin
            if (grant) begin
                last_src <= grant_src;
                cur_src  <= grant_src;
                if (src_is_read(grant_src)) begin
                    sdram_rd_req  <= 1'b1;
                    sdram_rd_addr <= grant_addr;
                    rd_sel        <= src_chan(grant_src);
                end else begin
                    sdram_wr_req  <= 1'b1;
                    sdram_wr_addr <= grant_addr;
                    wr_sel        <= src_chan(grant_src);
                end
            end
            if (state == ST_WREQ && sdram_wr_ack) sdram_wr_req <= 1'b0;
            if (state == ST_RREQ && sdram_rd_ack) sdram_rd_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: a small controller model answers each request
// with an ack pulse and every grant is compared against hand-computed values.
module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic [19:0] wr_level;
    logic [19:0] rd_space;
    logic [1:0]  rd_en;
    logic [1:0]  wr_frame_start;
    logic [1:0]  rd_frame_start;
    logic        sdram_wr_req;
    logic        sdram_wr_ack;
    logic [23:0] sdram_wr_addr;
    logic [9:0]  sdram_wr_burst;
    logic        sdram_rd_req;
    logic        sdram_rd_ack;
    logic [23:0] sdram_rd_addr;
    logic [9:0]  sdram_rd_burst;
    logic        wr_sel;
    logic        rd_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdram_port_arb #(
        .BURST       (256),
        .FRAME_WORDS (24'd1024),
        .BASE_CH0    (24'h000000),
        .BASE_CH1    (24'h400000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wr_level        (wr_level),
        .rd_space        (rd_space),
        .rd_en           (rd_en),
        .wr_frame_start  (wr_frame_start),
        .rd_frame_start  (rd_frame_start),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_wr_burst  (sdram_wr_burst),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_rd_burst  (sdram_rd_burst),
        .wr_sel          (wr_sel),
        .rd_sel          (rd_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serve one request; optionally pulse wr_frame_start while the burst is in flight.
    task automatic do_burst(input logic [1:0] wfs, output logic ok, output logic is_wr,
                            output logic sel, output logic [23:0] addr);
        int n = 0;
        while (!(sdram_wr_req || sdram_rd_req) && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = sdram_wr_req || sdram_rd_req;
        is_wr = sdram_wr_req;
        sel   = sdram_wr_req ? wr_sel : rd_sel;
        addr  = sdram_wr_req ? sdram_wr_addr : sdram_rd_addr;
        if (!ok) return;
        check("req_exclusive", {31'd0, sdram_wr_req & sdram_rd_req}, 32'd0);
        if (is_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
        @(negedge clk);
        check("req_drop_after_ack", {31'd0, sdram_wr_req | sdram_rd_req}, 32'd0);
        wr_frame_start = wfs;
        @(negedge clk);
        wr_frame_start = 2'b00;
        repeat (2) @(negedge clk);
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_burst(input string tag, input logic [1:0] wfs, input logic exp_wr,
                                input logic exp_sel, input logic [23:0] exp_addr);
        logic ok, is_wr, sel;
        logic [23:0] addr;
        do_burst(wfs, ok, is_wr, sel, addr);
        check({tag, "_req_seen"}, {31'd0, ok}, 32'd1);
        if (ok) begin
            check({tag, "_is_wr"}, {31'd0, is_wr}, {31'd0, exp_wr});
            check({tag, "_sel"},   {31'd0, sel},   {31'd0, exp_sel});
            check({tag, "_addr"},  {8'd0, addr},   {8'd0, exp_addr});
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            seen |= sdram_wr_req | sdram_rd_req;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        wr_level = '0;
        rd_space = '0;
        rd_en = '0;
        wr_frame_start = '0;
        rd_frame_start = '0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_wr_req",  {31'd0, sdram_wr_req}, 32'd0);
        check("rst_rd_req",  {31'd0, sdram_rd_req}, 32'd0);
        check("rst_wr_addr", {8'd0, sdram_wr_addr}, 32'd0);
        check("rst_rd_addr", {8'd0, sdram_rd_addr}, 32'd0);
        check("rst_sel",     {30'd0, wr_sel, rd_sel}, 32'd0);

        // Test 1: everything eligible but controller not initialised
        rst_n    = 1'b1;
        wr_level = {10'h3FF, 10'h3FF};
        rd_space = {10'h3FF, 10'h3FF};
        rd_en    = 2'b11;
        expect_quiet("t1_no_req_before_init", 10);
        check("wr_burst_len", {22'd0, sdram_wr_burst}, 32'd256);
        check("rd_burst_len", {22'd0, sdram_rd_burst}, 32'd256);
        sdram_init_done = 1'b1;
        expect_burst("t1_w0", 2'b00, 1'b1, 1'b0, 24'h000000);

        // Test 2: round robin over all four streams
        expect_burst("t2_r0", 2'b00, 1'b0, 1'b0, 24'h000000);
        check("t2_rd_sel_ch0", {31'd0, rd_sel}, 32'd0);
        expect_burst("t2_w1", 2'b00, 1'b1, 1'b1, 24'h400000);
        expect_burst("t2_r1", 2'b00, 1'b0, 1'b1, 24'h400000);
        check("t2_rd_sel_ch1", {31'd0, rd_sel}, 32'd1);
        expect_burst("t2_w0_again", 2'b00, 1'b1, 1'b0, 24'h000100);

        // Test 5: eligibility thresholds
        wr_level = '0;
        rd_en    = 2'b00;
        expect_quiet("t5_rd_en_off", 10);
        wr_level = {10'd0, 10'd255};
        expect_quiet("t5_level_255", 10);
        wr_level = {10'd0, 10'd256};
        // Test 4 rides on this burst: restart W0 while its burst at 0x200 is in flight
        expect_burst("t5_level_256", 2'b01, 1'b1, 1'b0, 24'h000200);
        expect_burst("t4_w0_restarted", 2'b00, 1'b1, 1'b0, 24'h000000);

        // Test 3: W1 alone, restart it while idle, then walk the 1024-word frame
        wr_level = '0;
        repeat (2) @(negedge clk);
        wr_frame_start = 2'b10;
        @(negedge clk);
        wr_frame_start = 2'b00;
        @(negedge clk);
        wr_level = {10'd300, 10'd0};
        for (int k = 0; k < 5; k++)
            expect_burst($sformatf("t3_w1_%0d", k), 2'b00, 1'b1, 1'b1, 24'h400000 + 24'((k % 4) * 256));

        // Test 6: asynchronous reset during a W1 burst
        begin
            int n = 0;
            while (!sdram_wr_req && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("t6_req_seen", {31'd0, sdram_wr_req}, 32'd1);
            sdram_wr_ack = 1'b1;
            repeat (2) @(negedge clk);
            check("t6_sel_before_rst",  {31'd0, wr_sel}, 32'd1);
            check("t6_addr_before_rst", {8'd0, sdram_wr_addr}, 32'h400100);
            #2 rst_n = 1'b0;
            #1;
            check("t6_rst_wr_req",  {31'd0, sdram_wr_req}, 32'd0);
            check("t6_rst_wr_sel",  {31'd0, wr_sel}, 32'd0);
            check("t6_rst_wr_addr", {8'd0, sdram_wr_addr}, 32'd0);
            sdram_wr_ack = 1'b0;
            @(negedge clk);
            rst_n    = 1'b1;
            wr_level = {10'h3FF, 10'h3FF};
            rd_en    = 2'b11;
            expect_burst("t6_w0_after_rst", 2'b00, 1'b1, 1'b0, 24'h000000);
            expect_burst("t6_r0_after_rst", 2'b00, 1'b0, 1'b0, 24'h000000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
